// File: rtl/hcp_tx_pkg.sv
// Shared constants for the HCP transmit arbiter: state encoding, Ethernet
// framing defaults, counter width and a saturating-increment helper.
package hcp_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE_S = 2'd0;
    localparam state_t XMIT_S = 2'd1;
    localparam state_t DROP_S = 2'd2;
    localparam state_t IFG_S  = 2'd3;

    localparam int ETH_MAX_FRAME = 1522;
    localparam int ETH_IFG       = 12;
    localparam int CNT_W         = 11;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/tx_arb_select_hcp.sv
// Arbitration decision between the two requesters. TX_ARB_RR_EN selects
// round-robin; otherwise port 0 has strict priority.
module tx_arb_select_hcp (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic [1:0] ov_grant
);

`ifdef TX_ARB_RR_EN
    logic ptr_r;

    // Tie goes to the port indicated by the pointer
    always_comb begin
        ov_grant = 2'b00;
        if (i_req0 && i_req1) begin
            if (ptr_r) begin
                ov_grant = 2'b10;
            end else begin
                ov_grant = 2'b01;
            end
        end else if (i_req0) begin
            ov_grant = 2'b01;
        end else if (i_req1) begin
            ov_grant = 2'b10;
        end else begin
            ov_grant = 2'b00;
        end
    end

    // Pointer moves to the other port whenever a grant is issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= 1'b0;
        end else if (i_en && (i_req0 || i_req1)) begin
            ptr_r <= ov_grant[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = i_clk ^ i_rst_n ^ i_en;

    // Port 0 always wins a simultaneous request
    always_comb begin
        ov_grant = 2'b00;
        if (i_req0) begin
            ov_grant = 2'b01;
        end else if (i_req1) begin
            ov_grant = 2'b10;
        end else begin
            ov_grant = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/tx_pkt_arbiter_hcp.sv
// Packet arbiter feeding the HCP TX CDC FIFO: byte mux, IFG enforcement,
// oversize truncation and overflow counting. Policy macro: TX_ARB_RR_EN.
module tx_pkt_arbiter_hcp
    import hcp_tx_pkg::*;
#(
    parameter int IFG_CYCLES    = ETH_IFG,
    parameter int MAX_PKT_BYTES = ETH_MAX_FRAME
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    output logic        o_grant0,
    output logic        o_grant1,
    input  logic [7:0]  iv_data0,
    input  logic [7:0]  iv_data1,
    input  logic        i_data_wr0,
    input  logic        i_data_wr1,
    input  logic        i_last0,
    input  logic        i_last1,
    output logic [7:0]  ov_pkt_data,
    output logic        o_pkt_data_wr,
    input  logic        i_fifo_overflow_pulse,
    output logic [15:0] ov_overflow_cnt,
    output logic        o_pkt_err_pulse,
    output logic        o_busy
);

    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PKT_BYTES);
    localparam logic [15:0]      IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic [15:0]        ifg_r, ifg_s;
    logic               grant0_r, grant0_s, grant1_r, grant1_s;
    logic [7:0]         data_r, data_s;
    logic               wr_r, wr_s, err_r, err_s, busy_r;
    logic [15:0]        ovf_r;
    logic [1:0]         pick_s;
    logic               sel_req_s, sel_wr_s, sel_last_s;
    logic [7:0]         sel_data_s;

    tx_arb_select_hcp u_select (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (state_r == IDLE_S),
        .i_req0   (i_req0),
        .i_req1   (i_req1),
        .ov_grant (pick_s)
    );

    // Only the granted requester's signals reach the FSM
    assign sel_req_s  = grant1_r ? i_req1     : i_req0;
    assign sel_wr_s   = grant1_r ? i_data_wr1 : i_data_wr0;
    assign sel_last_s = grant1_r ? i_last1    : i_last0;
    assign sel_data_s = grant1_r ? iv_data1   : iv_data0;
    assign cnt_inc_s  = cnt_r + 11'd1;

    // Next-state, grant and output-byte decisions
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ifg_s    = ifg_r;
        grant0_s = grant0_r;
        grant1_s = grant1_r;
        data_s   = data_r;
        wr_s     = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (i_req0 || i_req1) begin
                    grant0_s = pick_s[0];
                    grant1_s = pick_s[1];
                    cnt_s    = {CNT_W{1'b0}};
                    state_s  = XMIT_S;
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            end
            XMIT_S: begin
                if (sel_wr_s) begin
                    wr_s   = 1'b1;
                    data_s = sel_data_s;
                    cnt_s  = cnt_inc_s;
                end else begin
                    wr_s = 1'b0;
                end
                if (sel_wr_s && sel_last_s) begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                    ifg_s    = 16'd0;
                    state_s  = IFG_S;
                end else if (sel_wr_s && (cnt_inc_s == MAX_C)) begin
                    // Oversize: keep the grant so the requester can drain
                    err_s   = 1'b1;
                    state_s = DROP_S;
                end else if (!sel_req_s) begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                    err_s    = 1'b1;
                    ifg_s    = 16'd0;
                    state_s  = IFG_S;
                end else begin
                    state_s = XMIT_S;
                end
            end
            DROP_S: begin
                if ((sel_wr_s && sel_last_s) || !sel_req_s) begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                    ifg_s    = 16'd0;
                    state_s  = IFG_S;
                end else begin
                    state_s = DROP_S;
                end
            end
            IFG_S: begin
                if (ifg_r == IFG_LAST) begin
                    state_s = IDLE_S;
                end else begin
                    ifg_s = ifg_r + 16'd1;
                end
            end
            default: begin
                state_s  = IDLE_S;
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // FSM, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE_S;
            cnt_r    <= {CNT_W{1'b0}};
            ifg_r    <= 16'd0;
            grant0_r <= 1'b0;
            grant1_r <= 1'b0;
            data_r   <= 8'd0;
            wr_r     <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ifg_r    <= ifg_s;
            grant0_r <= grant0_s;
            grant1_r <= grant1_s;
            data_r   <= data_s;
            wr_r     <= wr_s;
            err_r    <= err_s;
            busy_r   <= (state_s != IDLE_S);
        end
    end

    // Overflow event counter, independent of arbitration
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_r <= 16'd0;
        end else if (i_fifo_overflow_pulse) begin
            ovf_r <= sat_inc16(ovf_r);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_grant0        = grant0_r;
    assign o_grant1        = grant1_r;
    assign ov_pkt_data     = data_r;
    assign o_pkt_data_wr   = wr_r;
    assign o_pkt_err_pulse = err_r;
    assign o_busy          = busy_r;
    assign ov_overflow_cnt = ovf_r;

endmodule

// File: tb/tb_tx_pkt_arbiter_hcp.sv
// Directed-plus-random bench for tx_pkt_arbiter_hcp with a packet-level model.
module tb_tx_pkt_arbiter_hcp;

    localparam int IFG  = 12;
    localparam int MAXB = 1522;
`ifdef TX_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
    logic [7:0]  data0 = 8'd0, data1 = 8'd0;
    logic        ovf_pulse = 1'b0;
    logic        o_grant0, o_grant1, o_pkt_data_wr, o_pkt_err_pulse, o_busy;
    logic [7:0]  ov_pkt_data;
    logic [15:0] ov_overflow_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #4 clk = ~clk;

    tx_pkt_arbiter_hcp #(.IFG_CYCLES(IFG), .MAX_PKT_BYTES(MAXB)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .o_grant0(o_grant0), .o_grant1(o_grant1),
        .iv_data0(data0), .iv_data1(data1),
        .i_data_wr0(wr0), .i_data_wr1(wr1),
        .i_last0(last0), .i_last1(last1),
        .ov_pkt_data(ov_pkt_data), .o_pkt_data_wr(o_pkt_data_wr),
        .i_fifo_overflow_pulse(ovf_pulse), .ov_overflow_cnt(ov_overflow_cnt),
        .o_pkt_err_pulse(o_pkt_err_pulse), .o_busy(o_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int out_cyc_q[$];
    int err_cyc_q[$];
    int gnt_q[$];
    int gap_bad = 0, both_high = 0, prev_wr_cyc = -1000;
    logic pg0 = 1'b0, pg1 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_pkt_data_wr) begin
                out_q.push_back(ov_pkt_data);
                out_cyc_q.push_back(cyc);
                if ((cyc - prev_wr_cyc > 1) && (cyc - prev_wr_cyc < IFG + 1)) gap_bad++;
                prev_wr_cyc = cyc;
            end
            if (o_pkt_err_pulse) err_cyc_q.push_back(cyc);
            if (o_grant0 && !pg0) gnt_q.push_back(0);
            if (o_grant1 && !pg1) gnt_q.push_back(1);
            if (o_grant0 && o_grant1) both_high++;
        end
        pg0 = o_grant0;
        pg1 = o_grant1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    endtask

    function automatic int qdiff();
        int d = 0;
        if (out_q.size() != exp_q.size()) d++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic clear_q();
        out_q.delete(); exp_q.delete(); out_cyc_q.delete();
        err_cyc_q.delete(); gnt_q.delete();
    endtask

    function automatic logic [31:0] all_outs();
        return {3'd0, o_grant0, o_grant1, ov_pkt_data, o_pkt_data_wr,
                ov_overflow_cnt, o_pkt_err_pulse, o_busy};
    endfunction

    task automatic drive(input int p, input logic r, input logic w, input logic l, input logic [7:0] d);
        if (p == 0) begin req0 = r; wr0 = w; last0 = l; data0 = d; end
        else begin req1 = r; wr1 = w; last1 = l; data1 = d; end
    endtask

    function automatic logic granted(input int p);
        return (p == 0) ? o_grant0 : o_grant1;
    endfunction

    task automatic send_pkt(input int p, input int len, input bit with_last, input bit keep_req,
                            output int first_drv, output int last_drv, output bit lost);
        int waitc = 0;
        logic [7:0] b;
        lost = 1'b0;
        drive(p, 1'b1, 1'b0, 1'b0, 8'd0);
        do begin @(posedge clk); #1; waitc++; end while (!granted(p) && waitc < 5000);
        check($sformatf("grant_wait_p%0d", p), {31'd0, granted(p)}, 32'd1);
        first_drv = cyc;
        last_drv = cyc;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (i < MAXB) exp_q.push_back(b);
            if (!granted(p)) lost = 1'b1;
            drive(p, 1'b1, 1'b1, with_last && (i == len - 1), b);
            last_drv = cyc;
            @(posedge clk); #1;
        end
        drive(p, keep_req, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic run_port(input int p, input int npkt);
        int f, l;
        bit lost;
        for (int k = 0; k < npkt; k++) send_pkt(p, 60, 1'b1, (k < npkt - 1), f, l, lost);
    endtask

    task automatic pulse_ovf(input int n);
        ovf_pulse = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        ovf_pulse = 1'b0;
    endtask

    initial begin
        #(8 * 98000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f, l, w, p0, p1, win;
        bit lost, ptr;
        int exp_order[$];

        #1;
        check("reset_outputs", all_outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Simultaneous requests, port 0 holds req across three packets
        fork
            run_port(0, 3);
            run_port(1, 2);
        join
        repeat (20) @(posedge clk);
        #1;
        p0 = 3; p1 = 2; ptr = 1'b0;
        while (p0 > 0 || p1 > 0) begin
            if (p0 > 0 && p1 > 0) win = RR_MODE ? int'(ptr) : 0;
            else win = (p0 > 0) ? 0 : 1;
            ptr = (win == 0);
            exp_order.push_back(win);
            if (win == 0) p0--; else p1--;
        end
        check("order_len", gnt_q.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < gnt_q.size(); i++)
            check($sformatf("order_%0d", i), gnt_q[i], exp_order[i]);
        check("arb_bytes", qdiff(), 32'd0);
        check("arb_nbytes", out_q.size(), 32'd300);
        check("arb_gap", gap_bad, 32'd0);
        clear_q();

        // Single 64-byte packet on port 0
        send_pkt(0, 64, 1'b1, 1'b0, f, l, lost);
        check("p64_last_wr", {31'd0, o_pkt_data_wr}, 32'd1);
        check("p64_last_byte", {24'd0, ov_pkt_data}, {24'd0, exp_q[exp_q.size() - 1]});
        check("p64_grant_low", {31'd0, o_grant0}, 32'd0);
        repeat (IFG - 1) @(posedge clk);
        #1 check("p64_busy_in_ifg", {31'd0, o_busy}, 32'd1);
        @(posedge clk);
        #1 check("p64_busy_after_ifg", {31'd0, o_busy}, 32'd0);
        check("p64_bytes", qdiff(), 32'd0);
        check("p64_latency", out_cyc_q[0], f + 1);
        check("p64_contig", out_cyc_q[out_cyc_q.size() - 1] - out_cyc_q[0], 32'd63);
        check("p64_no_err", err_cyc_q.size(), 32'd0);
        clear_q();

        // Oversize 1600-byte frame on port 1
        send_pkt(1, 1600, 1'b1, 1'b0, f, l, lost);
        check("big_grant_held", {31'd0, lost}, 32'd0);
        check("big_grant_low", {31'd0, o_grant1}, 32'd0);
        check("big_wr_low", {31'd0, o_pkt_data_wr}, 32'd0);
        repeat (IFG + 2) @(posedge clk);
        #1;
        check("big_nbytes", out_q.size(), MAXB);
        check("big_bytes", qdiff(), 32'd0);
        check("big_err_cnt", err_cyc_q.size(), 32'd1);
        if (err_cyc_q.size() > 0) check("big_err_cyc", err_cyc_q[0], f + MAXB);
        clear_q();

        // Port 0 aborts after 10 bytes, then port 1 sends normally
        send_pkt(0, 10, 1'b0, 1'b0, f, l, lost);
        repeat (2) @(posedge clk);
        #1;
        check("abort_err_cnt", err_cyc_q.size(), 32'd1);
        if (err_cyc_q.size() > 0) check("abort_err_cyc", err_cyc_q[0], l + 2);
        check("abort_nbytes", out_q.size(), 32'd10);
        send_pkt(1, 20, 1'b1, 1'b0, f, l, lost);
        repeat (IFG + 2) @(posedge clk);
        #1;
        check("abort_then_p1_bytes", qdiff(), 32'd0);
        check("abort_then_p1_err", err_cyc_q.size(), 32'd1);
        clear_q();

        // Port 1 writes while port 0 owns the output
        fork
            send_pkt(0, 40, 1'b1, 1'b0, f, l, lost);
            begin
                int ws = 0;
                while (!o_grant0 && ws < 100) begin @(posedge clk); #1; ws++; end
                for (int i = 0; i < 45; i++) begin
                    data1 = 8'($urandom);
                    last1 = 1'($urandom_range(0, 1));
                    wr1 = 1'b1;
                    @(posedge clk); #1;
                end
                wr1 = 1'b0; last1 = 1'b0;
            end
        join
        repeat (IFG + 2) @(posedge clk);
        #1;
        check("nongrant_nbytes", out_q.size(), 32'd40);
        check("nongrant_bytes", qdiff(), 32'd0);
        clear_q();

        // Overflow counter saturation, running alongside a packet
        pulse_ovf(3);
        check("ovf_3", {16'd0, ov_overflow_cnt}, 32'd3);
        fork
            pulse_ovf(65531);
            send_pkt(0, 64, 1'b1, 1'b0, f, l, lost);
        join
        check("ovf_fffe", {16'd0, ov_overflow_cnt}, 32'h0000FFFE);
        check("ovf_pkt_bytes", qdiff(), 32'd0);
        pulse_ovf(6);
        check("ovf_sat", {16'd0, ov_overflow_cnt}, 32'h0000FFFF);
        clear_q();

        // Asynchronous reset in the middle of a packet
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0);
        w = 0;
        while (!o_grant0 && w < 100) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 8'($urandom));
            @(posedge clk); #1;
        end
        check("rst_pre_busy", {30'd0, o_grant0, o_busy}, 32'd3);
        #1 rst_n = 1'b0;
        #1 check("rst_async_outputs", all_outs(), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_q();
        send_pkt(1, 30, 1'b1, 1'b0, f, l, lost);
        repeat (IFG + 2) @(posedge clk);
        #1;
        check("post_rst_bytes", qdiff(), 32'd0);
        check("post_rst_no_err", err_cyc_q.size(), 32'd0);
        check("one_grant_max", both_high, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_pkt_arbiter_hcp.md
# tx_pkt_arbiter_hcp

Packet-level arbiter in front of the HCP network transmit path. Two byte-stream requesters (port 0: HCP-generated control packets, port 1: forwarded packets) share the single 8-bit write interface of the TX clock-domain-crossing FIFO. The arbiter:

- grants one requester per packet and forwards its bytes with fixed latency;
- enforces a minimum idle gap between packets and truncates oversize frames;
- counts FIFO overflow events reported back from the crossing stage.

## Interface
Parameters:
- IFG_CYCLES, 12, idle i_clk cycles enforced between the last byte of one packet and the next grant
- MAX_PKT_BYTES, 1522, maximum forwarded bytes per packet; range 64..2047

Ports:
- i_clk  in  1  125 MHz core clock; the only clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req0 / i_req1  in  1  requester has a packet pending; held until its last byte is written
- o_grant0 / o_grant1  out  1  requester owns the output; at most one high
- iv_data0 / iv_data1  in  8  packet byte
- i_data_wr0 / i_data_wr1  in  1  byte valid
- i_last0 / i_last1  in  1  qualifies the final byte (valid only with wr)
- ov_pkt_data  out  8  byte to TX CDC FIFO
- o_pkt_data_wr  out  1  FIFO write strobe
- i_fifo_overflow_pulse  in  1  one-cycle pulse from the CDC stage, i_clk domain
- ov_overflow_cnt  out  16  saturating overflow event count
- o_pkt_err_pulse  out  1  one-cycle pulse on truncation or abort
- o_busy  out  1  state is not IDLE

## Operation
- Reset value of every output is 0. State resets to IDLE, the byte counter to 0, and the RR pointer to 0.
- States: IDLE, XMIT, DROP, IFG.
- IDLE:
  - If any req is high, select the winner and register its grant.
  - Go to XMIT.
- XMIT:
  - Each wr from the granted requester is forwarded. ov_pkt_data and o_pkt_data_wr are both registered.
  - The byte counter increments, 11 bits wide.
  - A wr from the non-granted requester is ignored and never forwarded.
  - wr&last, or a wr that makes count == MAX_PKT_BYTES: clear grant and go to IFG.
    - If the count limit was hit and that byte is not last, pulse o_pkt_err_pulse and go to DROP instead.
  - Granted req falls with no last seen: clear grant, pulse o_pkt_err_pulse, go to IFG. This covers an abort with zero bytes.
- DROP:
  - Grant stays high so the requester can drain. Its bytes are discarded, with o_pkt_data_wr = 0.
  - On wr&last or req low, clear grant and go to IFG.
- IFG:
  - Count IFG_CYCLES cycles, then go to IDLE.
  - Requests arriving during IFG are held pending and are not lost.
- Overflow counter:
  - Increments on each i_fifo_overflow_pulse and saturates at 16'hFFFF.
  - It is independent of state and does not stop arbitration.
- No backpressure to requesters exists; the FIFO is sized by the CDC stage.

## Timing
- Arbitration: req sampled in IDLE at cycle N; grant high at N+1.
- Data latency: requester wr at cycle M; o_pkt_data_wr at M+1 with the same byte. Back-to-back bytes come out back-to-back.
- Grant falls the cycle after the terminating byte is sampled. The last forwarded byte and the grant deassertion are in the same cycle.
- Gap: the last o_pkt_data_wr is at cycle L. The earliest next grant is at L + IFG_CYCLES + 1, and the earliest next output byte is L + IFG_CYCLES + 3.
- Both reqs rising in the same cycle: resolved by the arbitration policy (see Configuration).
- Reset mid-packet: outputs drop to 0 asynchronously. The partial packet is not completed. Requesters restart from their own reset.

## Configuration
- TX_ARB_RR_EN defined: round-robin.
  - After serving port k, port 1-k wins when both request.
  - The pointer updates when the grant is issued.
- Undefined: strict priority; port 0 always wins a simultaneous request.
  - Port 1 can starve; this is accepted for control traffic.

## Structure
- Shared package hcp_tx_pkg:
  - state encoding localparams (IDLE_S=2'd0, XMIT_S=2'd1, DROP_S=2'd2, IFG_S=2'd3);
  - ETH_MAX_FRAME=1522 and ETH_IFG=12 constants;
  - a counter-width constant of 11.
- The arbitration decision (policy plus RR pointer) sits in one sub-module, tx_arb_select_hcp: inputs are the reqs and an enable, outputs are a one-hot grant. The macro affects only this sub-module.
- The byte mux, FSM and counters stay in the top level.

## Test plan
- Single packet, port 0, 64 bytes with last on byte 64 -> 64 contiguous o_pkt_data_wr, bytes matching, 1-cycle delay; grant0 low in the cycle after byte 64; o_busy low after IFG.
- Simultaneous req0/req1 with 60-byte packets each:
  - strict priority: order 0,0,0 while req0 stays high;
  - TX_ARB_RR_EN: order 0,1,0,1;
  - in both modes, a gap of ≥12 idle cycles between packets.
- Port 1 sends 1600 bytes -> exactly 1522 forwarded; o_pkt_err_pulse one cycle after byte 1522; the remaining 78 bytes dropped; grant1 held until last.
- Port 0 drops req after 10 bytes with no last -> 10 bytes out, err pulse, IFG, then port 1 granted normally.
- Port 1 drives wr while port 0 is granted -> no port-1 bytes on the output.
- 70000 overflow pulses -> ov_overflow_cnt = 16'hFFFF; async reset mid-XMIT -> all outputs 0 immediately and counter 0.
